// File: rtl/mont_exp_sequencer.sv
// -----------------------------------------------------------------------------
// mont_exp_sequencer
//
// Purpose:
//   Control stage in front of the Montgomery multiplier. It computes x^e by
//   left-to-right square-and-multiply. All operands are already in Montgomery
//   form, so the accumulator starts at R mod M (Montgomery one).
//
// Optional feature (compile-time macro):
//   MONT_EXP_SKIP_LEADING_ZEROS_EN - when defined, a LOAD state scans down from
//   the exponent MSB to the first set bit, one bit per cycle. At that bit the
//   accumulator is loaded with the base directly, so the leading squarings of
//   one and the first multiply are never issued. For e=0 no multiplies are
//   issued at all.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            one-cycle request, sampled only in IDLE
//   in_base          base x (Montgomery form)
//   in_one           R mod M (Montgomery one)
//   in_exp           exponent e
//   in_m             modulus M
//   out_read         consumer acknowledge of result/done
//   result, done     x^e (Montgomery form); done is a level held until out_read
//   busy             high in every state except IDLE and DONE
//   mul_start        one-cycle start pulse to the multiplier
//   mul_a/b/m        registered multiplier operands
//   mul_out_read     one-cycle acknowledge to the multiplier
//   mul_result       multiplier product
//   mul_done         multiplier result valid (level)
// -----------------------------------------------------------------------------
module mont_exp_sequencer #(
  parameter int WIDTH     = 381,
  parameter int EXP_WIDTH = 381,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_base,
  input  logic [WIDTH-1:0]     in_one,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [WIDTH-1:0]     in_m,
  input  logic                 out_read,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  output logic                 mul_out_read,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_done
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SQ_SETUP  = 4'd1;
  localparam logic [3:0] S_SQ_START  = 4'd2;
  localparam logic [3:0] S_SQ_WAIT   = 4'd3;
  localparam logic [3:0] S_MUL_SETUP = 4'd4;
  localparam logic [3:0] S_MUL_START = 4'd5;
  localparam logic [3:0] S_MUL_WAIT  = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
  localparam logic [3:0] S_LOAD      = 4'd9;
`endif

  logic [3:0]           r_state;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_m;
  logic [IW-1:0]        r_idx;
  logic [SW-1:0]        r_settle;
  logic [WIDTH-1:0]     r_result;
  logic                 r_done;
  logic                 r_mul_start;
  logic                 r_mul_out_read;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [WIDTH-1:0]     r_mul_m;

  logic                 w_exp_bit;
  logic                 w_last_bit;

  assign w_exp_bit  = r_exp[r_idx];
  assign w_last_bit = (r_idx == '0);

  assign result       = r_result;
  assign done         = r_done;
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign mul_start    = r_mul_start;
  assign mul_out_read = r_mul_out_read;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign mul_m        = r_mul_m;

  // Operands are written only on the edge that enters a *_SETUP state, so
  // they are stable for the whole SETUP window and until the next SETUP.
  // The SETUP window therefore provides the settle time the multiplier needs
  // to derive 2B/3B before it sees mul_start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_base         <= '0;
      r_exp          <= '0;
      r_m            <= '0;
      r_idx          <= '0;
      r_settle       <= '0;
      r_result       <= '0;
      r_done         <= 1'b0;
      r_mul_start    <= 1'b0;
      r_mul_out_read <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_m        <= '0;
    end else begin
      r_mul_start    <= 1'b0;
      r_mul_out_read <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= in_one;
            r_base <= in_base;
            r_exp  <= in_exp;
            r_m    <= in_m;
            r_idx  <= IW'(EXP_WIDTH - 1);
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
            r_state <= S_LOAD;
`else
            r_mul_a <= in_one;
            r_mul_b <= in_one;
            r_mul_m <= in_m;
            r_state <= S_SQ_SETUP;
`endif
          end
        end

        S_SQ_SETUP, S_MUL_SETUP: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_settle    <= '0;
            r_mul_start <= 1'b1;
            r_state     <= (r_state == S_SQ_SETUP) ? S_SQ_START : S_MUL_START;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end

        S_SQ_START:  r_state <= S_SQ_WAIT;
        S_MUL_START: r_state <= S_MUL_WAIT;

        S_SQ_WAIT: begin
          if (mul_done) begin
            r_acc          <= mul_result;
            r_mul_out_read <= 1'b1;
            if (w_exp_bit) begin
              // Multiply by base uses the freshly squared value directly.
              r_mul_a <= mul_result;
              r_mul_b <= r_base;
              r_state <= S_MUL_SETUP;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end

        S_MUL_WAIT: begin
          if (mul_done) begin
            r_acc          <= mul_result;
            r_mul_out_read <= 1'b1;
            r_state        <= S_NEXT;
          end
        end

        // Always at least one cycle here after mul_out_read, which lets the
        // multiplier return to idle before the operands change again.
        S_NEXT: begin
          if (w_last_bit) begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx   <= r_idx - IW'(1);
            r_mul_a <= r_acc;
            r_mul_b <= r_acc;
            r_mul_m <= r_m;
            r_state <= S_SQ_SETUP;
          end
        end

        // start is deliberately not looked at here, even alongside out_read.
        S_DONE: begin
          if (out_read) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
        // Leading-zero scan: squaring one is a no-op, and the first multiply
        // by base is just a copy, so both are replaced by a register load.
        S_LOAD: begin
          if (w_exp_bit) begin
            r_acc   <= r_base;
            r_state <= S_NEXT;
          end else if (w_last_bit) begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
module tb_mont_exp_sequencer;

  localparam int WIDTH     = 8;
  localparam int EXP_WIDTH = 8;
  localparam int SETTLE    = 2;
  localparam int LAT       = 10;
  localparam int MOD       = 97;
  localparam int RMOD      = 62;   // 256 mod 97
  localparam int RINV      = 36;   // 62*36 = 2232 = 23*97 + 1

`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
  localparam int PULSES_A5   = 10;
  localparam int PULSES_ZERO = 0;
  localparam int PULSES_03   = 2;
`else
  localparam int PULSES_A5   = 12;
  localparam int PULSES_ZERO = 8;
  localparam int PULSES_03   = 10;
`endif

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 start;
  logic [WIDTH-1:0]     in_base;
  logic [WIDTH-1:0]     in_one;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [WIDTH-1:0]     in_m;
  logic                 out_read;
  logic [WIDTH-1:0]     result;
  logic                 done;
  logic                 busy;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [WIDTH-1:0]     mul_m;
  logic                 mul_out_read;
  logic [WIDTH-1:0]     mul_result;
  logic                 mul_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mont_exp_sequencer #(
    .WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_base(in_base), .in_one(in_one), .in_exp(in_exp), .in_m(in_m),
    .out_read(out_read), .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_out_read(mul_out_read), .mul_result(mul_result), .mul_done(mul_done)
  );

  // Mock multiplier plus protocol monitor, both evaluated on the falling edge.
  int             n_pulses = 0;
  int             n_viol = 0;
  int             n_done_rise = 0;
  int             since_or = 100;
  int             mk_cnt = 0;
  logic           mk_busy = 1'b0;
  logic [WIDTH-1:0] ca, cb, cm;
  logic [WIDTH-1:0] h1a, h1b, h1m, h2a, h2b, h2m;
  logic           prev_or = 1'b0, prev_start = 1'b0, prev_done = 1'b0;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      mk_busy = 1'b0; mk_cnt = 0; mul_done = 1'b0; mul_result = '0;
      h1a = '0; h1b = '0; h1m = '0; h2a = '0; h2b = '0; h2m = '0;
      prev_or = 1'b0; prev_start = 1'b0; prev_done = 1'b0; since_or = 100;
    end else begin
      if (mul_start) begin
        n_pulses++;
        if (mul_a !== h1a || mul_b !== h1b || mul_m !== h1m ||
            mul_a !== h2a || mul_b !== h2b || mul_m !== h2m) n_viol++;
        if (prev_start) n_viol++;
        if (since_or < 1) n_viol++;
      end
      if (mk_busy && (mul_a !== ca || mul_b !== cb || mul_m !== cm)) n_viol++;
      if (mul_out_read && prev_or) n_viol++;
      if (done && !prev_done) n_done_rise++;
      since_or = mul_out_read ? 0 : ((since_or < 100) ? since_or + 1 : 100);
      h2a = h1a; h2b = h1b; h2m = h1m;
      h1a = mul_a; h1b = mul_b; h1m = mul_m;
      prev_or = mul_out_read; prev_start = mul_start; prev_done = done;

      if (mul_out_read) mul_done = 1'b0;
      if (mul_start && !mk_busy) begin
        mk_busy = 1'b1; mk_cnt = LAT; ca = mul_a; cb = mul_b; cm = mul_m;
      end else if (mk_busy) begin
        mk_cnt--;
        if (mk_cnt == 0) begin
          mk_busy    = 1'b0;
          mul_done   = 1'b1;
          mul_result = WIDTH'((int'(ca) * int'(cb) * RINV) % int'(cm));
        end
      end
    end
  end

  function automatic int to_mont(input int x);
    return (x * RMOD) % MOD;
  endfunction

  // x^e computed by plain repeated multiplication in the normal domain,
  // then mapped into Montgomery form.
  function automatic int exp_model(input int x, input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = (p * x) % MOD;
    return (p * RMOD) % MOD;
  endfunction

  task automatic do_start(input int b, input int e);
    @(negedge clk);
    in_base = WIDTH'(b); in_one = WIDTH'(RMOD); in_exp = EXP_WIDTH'(e);
    in_m = WIDTH'(MOD); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic ack_result();
    @(negedge clk); out_read = 1'b1;
    @(negedge clk); out_read = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; out_read = 1'b0;
    in_base = '0; in_one = '0; in_exp = '0; in_m = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (result !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_result_done: got result=%0d done=%0b, expected 0/0", result, done);
    end
    n_checks++;
    if (busy !== 1'b0 || mul_start !== 1'b0 || mul_out_read !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got busy=%0b start=%0b out_read=%0b, expected 0", busy, mul_start, mul_out_read);
    end
    n_checks++;
    if (mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
      n_fail++; $display("FAIL reset_operands: got a=%0d b=%0d m=%0d, expected 0", mul_a, mul_b, mul_m);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got busy=%0b done=%0b, expected 0/0", busy, done);
    end
  endtask

  task automatic test_exp_a5();
    int p0, r0, v0;
    bit to;
    logic [WIDTH-1:0] exp_v;
    p0 = n_pulses; r0 = n_done_rise; v0 = n_viol;
    exp_v = WIDTH'(exp_model(5, 165));
    do_start(to_mont(5), 8'hA5);
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL a5_timeout: done never rose within 2000 cycles"); end
    n_checks++;
    if (result !== exp_v) begin
      n_fail++; $display("FAIL a5_result: got %0d expected %0d", result, exp_v);
    end
    n_checks++;
    if (n_pulses - p0 != PULSES_A5) begin
      n_fail++; $display("FAIL a5_pulses: got %0d expected %0d", n_pulses - p0, PULSES_A5);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_in_done: got %0b expected 0", busy); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || result !== exp_v) begin
      n_fail++; $display("FAIL a5_done_held: got done=%0b result=%0d expected 1/%0d", done, result, exp_v);
    end
    n_checks++;
    if (n_done_rise - r0 != 1) begin
      n_fail++; $display("FAIL a5_done_rises: got %0d expected 1", n_done_rise - r0);
    end
    ack_result();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL a5_done_clear: got %0b expected 0", done); end
    n_checks++;
    if (n_viol != v0) begin
      n_fail++; $display("FAIL a5_protocol: got %0d violations expected 0", n_viol - v0);
    end
  endtask

  task automatic test_exp_zero();
    int p0, v0;
    bit to;
    p0 = n_pulses; v0 = n_viol;
    do_start(to_mont(5), 0);
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL zero_timeout: done never rose within 2000 cycles"); end
    n_checks++;
    if (result !== WIDTH'(RMOD)) begin
      n_fail++; $display("FAIL zero_result: got %0d expected %0d", result, RMOD);
    end
    n_checks++;
    if (n_pulses - p0 != PULSES_ZERO) begin
      n_fail++; $display("FAIL zero_pulses: got %0d expected %0d", n_pulses - p0, PULSES_ZERO);
    end
    n_checks++;
    if (n_viol != v0) begin
      n_fail++; $display("FAIL zero_protocol: got %0d violations expected 0", n_viol - v0);
    end
    ack_result();
  endtask

  task automatic test_reset_mid();
    int p0, v0;
    bit to;
    logic [WIDTH-1:0] exp_v;
    exp_v = WIDTH'(exp_model(3, 165));
    p0 = n_pulses;
    do_start(to_mont(3), 8'hA5);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_pulses - p0 >= 3) begin to = 1'b0; break; end
    end
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mid_third_pulse_timeout: got %0d pulses expected 3", n_pulses - p0); end
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_status: got result=%0d done=%0b busy=%0b expected 0", result, done, busy);
    end
    n_checks++;
    if (mul_start !== 1'b0 || mul_out_read !== 1'b0 ||
        mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
      n_fail++; $display("FAIL mid_reset_mul_if: got start=%0b rd=%0b a=%0d b=%0d m=%0d expected 0",
                         mul_start, mul_out_read, mul_a, mul_b, mul_m);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    p0 = n_pulses; v0 = n_viol;
    do_start(to_mont(3), 8'hA5);
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mid_restart_timeout: done never rose within 2000 cycles"); end
    n_checks++;
    if (result !== exp_v) begin
      n_fail++; $display("FAIL mid_restart_result: got %0d expected %0d", result, exp_v);
    end
    n_checks++;
    if (n_pulses - p0 != PULSES_A5) begin
      n_fail++; $display("FAIL mid_restart_pulses: got %0d expected %0d", n_pulses - p0, PULSES_A5);
    end
    n_checks++;
    if (n_viol != v0) begin
      n_fail++; $display("FAIL mid_restart_protocol: got %0d violations expected 0", n_viol - v0);
    end
    ack_result();
  endtask

  task automatic test_ignore_start();
    int p0, p1;
    bit to;
    logic [WIDTH-1:0] exp_v;
    exp_v = WIDTH'(exp_model(5, 165));
    p0 = n_pulses;
    do_start(to_mont(5), 8'hA5);
    for (int k = 0; k < 4; k++) begin
      repeat (20) @(negedge clk);
      in_base = WIDTH'(to_mont(7)); in_exp = 8'h03; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL busy_start_timeout: done never rose within 2000 cycles"); end
    n_checks++;
    if (result !== exp_v || n_pulses - p0 != PULSES_A5) begin
      n_fail++; $display("FAIL busy_start_ignored: got result=%0d pulses=%0d expected %0d/%0d",
                         result, n_pulses - p0, exp_v, PULSES_A5);
    end
    // start together with out_read in DONE
    p1 = n_pulses;
    @(negedge clk);
    in_base = WIDTH'(to_mont(7)); in_exp = 8'h03; start = 1'b1; out_read = 1'b1;
    @(negedge clk);
    start = 1'b0; out_read = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ack: got done=%0b busy=%0b expected 0/0", done, busy);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || n_pulses != p1) begin
      n_fail++; $display("FAIL done_start_ignored: got busy=%0b pulses=%0d expected 0/0", busy, n_pulses - p1);
    end
    exp_v = WIDTH'(exp_model(7, 3));
    do_start(to_mont(7), 8'h03);
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL idle_start_timeout: done never rose within 2000 cycles"); end
    n_checks++;
    if (result !== exp_v || n_pulses - p1 != PULSES_03) begin
      n_fail++; $display("FAIL idle_start_result: got result=%0d pulses=%0d expected %0d/%0d",
                         result, n_pulses - p1, exp_v, PULSES_03);
    end
    ack_result();
  endtask

  initial begin
    test_reset();
    test_exp_a5();
    test_exp_zero();
    test_reset_mid();
    test_ignore_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
